// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction queue between 4-wide fetch and decode; accepts
// a 4-entry group per cycle, presents the oldest 4 entries and retires 0-4 of them.
module fetch_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          flush,
  input  logic          push_valid,
  input  logic [31:0]   InstrF1,
  input  logic [31:0]   InstrF2,
  input  logic [31:0]   InstrF3,
  input  logic [31:0]   InstrF4,
  input  logic [31:0]   PCPlus4F1,
  input  logic [31:0]   PCPlus4F2,
  input  logic [31:0]   PCPlus4F3,
  input  logic [31:0]   PCPlus4F4,
  input  logic [2:0]    consume,
  output logic          stall,
  output logic [31:0]   InstrD1,
  output logic [31:0]   InstrD2,
  output logic [31:0]   InstrD3,
  output logic [31:0]   InstrD4,
  output logic [31:0]   PCPlus4D1,
  output logic [31:0]   PCPlus4D2,
  output logic [31:0]   PCPlus4D3,
  output logic [31:0]   PCPlus4D4,
  output logic [3:0]    ValidD,
  output logic [AW:0]   count
);
  logic [31:0] r_instr [DEPTH];
  logic [31:0] r_pc [DEPTH];
  logic [AW-1:0] r_head, r_tail;
  logic [AW:0] r_count;
  logic [31:0] w_fi [4];
  logic [31:0] w_fp [4];
  logic [31:0] w_di [4];
  logic [31:0] w_dp [4];
  logic [AW:0] w_free;
  logic [2:0] w_avail, w_n;
  logic w_push;
  assign w_fi = '{InstrF1, InstrF2, InstrF3, InstrF4};
  assign w_fp = '{PCPlus4F1, PCPlus4F2, PCPlus4F3, PCPlus4F4};
  // stall depends on registered count only, so decode's consume never loops back to fetch
  assign w_free = (AW+1)'(DEPTH) - r_count;
  assign stall = w_free < (AW+1)'(4);
  assign w_push = push_valid && !stall && !flush;
  assign w_avail = r_count > (AW+1)'(4) ? 3'd4 : 3'(r_count);
  assign w_n = consume > w_avail ? w_avail : consume;
  assign count = r_count;
  always_comb begin
    ValidD = '0;
    for (int i = 0; i < 4; i++) begin
      ValidD[i] = r_count > (AW+1)'(i);
      w_di[i] = r_count > (AW+1)'(i) ? r_instr[r_head + AW'(i)] : '0;
      w_dp[i] = r_count > (AW+1)'(i) ? r_pc[r_head + AW'(i)] : '0;
    end
  end
  assign InstrD1 = w_di[0];
  assign InstrD2 = w_di[1];
  assign InstrD3 = w_di[2];
  assign InstrD4 = w_di[3];
  assign PCPlus4D1 = w_dp[0];
  assign PCPlus4D2 = w_dp[1];
  assign PCPlus4D3 = w_dp[2];
  assign PCPlus4D4 = w_dp[3];
  always_ff @(posedge CLK) begin
    if (w_push && !reset)
      for (int k = 0; k < 4; k++) begin
        r_instr[r_tail + AW'(k)] <= w_fi[k];
        r_pc[r_tail + AW'(k)] <= w_fp[k];
      end
  end
  always_ff @(posedge CLK) begin
    if (reset || flush) begin
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
    end else begin
      r_head <= r_head + AW'(w_n);
      r_tail <= w_push ? r_tail + AW'(4) : r_tail;
      r_count <= r_count + (w_push ? (AW+1)'(4) : '0) - (AW+1)'(w_n);
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: table vectors, hand sequences and random traffic against a queue model.
module tb_fetch_queue;
  logic CLK = 0, reset = 1, flush = 0, push_valid = 0;
  logic [31:0] InstrF1 = 0, InstrF2 = 0, InstrF3 = 0, InstrF4 = 0;
  logic [31:0] PCPlus4F1 = 0, PCPlus4F2 = 0, PCPlus4F3 = 0, PCPlus4F4 = 0;
  logic [2:0] consume = 0;
  logic stall;
  logic [31:0] InstrD1, InstrD2, InstrD3, InstrD4;
  logic [31:0] PCPlus4D1, PCPlus4D2, PCPlus4D3, PCPlus4D4;
  logic [3:0] ValidD;
  logic [3:0] count;
  int errors = 0, checks = 0;
  logic [63:0] q [$];

  fetch_queue #(.DEPTH(8), .AW(3)) dut (
    .CLK(CLK), .reset(reset), .flush(flush), .push_valid(push_valid),
    .InstrF1(InstrF1), .InstrF2(InstrF2), .InstrF3(InstrF3), .InstrF4(InstrF4),
    .PCPlus4F1(PCPlus4F1), .PCPlus4F2(PCPlus4F2), .PCPlus4F3(PCPlus4F3), .PCPlus4F4(PCPlus4F4),
    .consume(consume), .stall(stall),
    .InstrD1(InstrD1), .InstrD2(InstrD2), .InstrD3(InstrD3), .InstrD4(InstrD4),
    .PCPlus4D1(PCPlus4D1), .PCPlus4D2(PCPlus4D2), .PCPlus4D3(PCPlus4D3), .PCPlus4D4(PCPlus4D4),
    .ValidD(ValidD), .count(count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit fl; bit pv; logic [31:0] ib; logic [31:0] pb; logic [2:0] cons;
    int cnt; bit stl; logic [3:0] vd; logic [31:0] i1; logic [31:0] i2;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_check(input string tag);
    logic [31:0] ai [4];
    logic [31:0] ap [4];
    logic [3:0] ev;
    ai = '{InstrD1, InstrD2, InstrD3, InstrD4};
    ap = '{PCPlus4D1, PCPlus4D2, PCPlus4D3, PCPlus4D4};
    ev = '0;
    for (int i = 0; i < 4; i++) begin
      ev[i] = q.size() > i;
      chk($sformatf("%s instr%0d", tag, i + 1), ai[i], q.size() > i ? q[i][63:32] : 32'h0);
      chk($sformatf("%s pc%0d", tag, i + 1), ap[i], q.size() > i ? q[i][31:0] : 32'h0);
    end
    chk({tag, " valid"}, 32'(ValidD), 32'(ev));
    chk({tag, " count"}, 32'(count), 32'(q.size()));
    chk({tag, " stall"}, 32'(stall), 32'((8 - q.size()) < 4));
  endtask

  // lane k of a group carries ib*k / pb*k
  task automatic step(input bit fl, input bit pv, input logic [31:0] ib, input logic [31:0] pb,
                      input logic [2:0] cons, input string tag);
    bit acc;
    int nv, n;
    flush = fl; push_valid = pv; consume = cons;
    InstrF1 = ib; InstrF2 = ib * 2; InstrF3 = ib * 3; InstrF4 = ib * 4;
    PCPlus4F1 = pb; PCPlus4F2 = pb * 2; PCPlus4F3 = pb * 3; PCPlus4F4 = pb * 4;
    #1 model_check(tag);
    acc = pv && ((8 - q.size()) >= 4) && !fl;
    nv = q.size() < 4 ? q.size() : 4;
    n = int'(cons) > nv ? nv : int'(cons);
    @(posedge CLK); #1;
    if (fl) q.delete();
    else begin
      repeat (n) void'(q.pop_front());
      if (acc) for (int k = 1; k <= 4; k++) q.push_back({32'(ib * k), 32'(pb * k)});
    end
  endtask

  initial begin
    tbl[0]  = '{0, 1, 32'h11,   32'h4,  3'd0, 4, 0, 4'hf, 32'h11,  32'h22};
    tbl[1]  = '{0, 1, 32'h100,  32'h40, 3'd3, 5, 1, 4'hf, 32'h44,  32'h100};
    tbl[2]  = '{0, 1, 32'h200,  32'h80, 3'd0, 5, 1, 4'hf, 32'h44,  32'h100};
    tbl[3]  = '{0, 0, 32'h0,    32'h0,  3'd4, 1, 0, 4'h1, 32'h400, 32'h0};
    tbl[4]  = '{0, 1, 32'h10,   32'h8,  3'd7, 4, 0, 4'hf, 32'h10,  32'h20};
    tbl[5]  = '{0, 1, 32'h1000, 32'h4,  3'd0, 8, 1, 4'hf, 32'h10,  32'h20};
    tbl[6]  = '{0, 1, 32'h5,    32'h4,  3'd0, 8, 1, 4'hf, 32'h10,  32'h20};
    tbl[7]  = '{1, 1, 32'h9,    32'h4,  3'd2, 0, 0, 4'h0, 32'h0,   32'h0};
    tbl[8]  = '{0, 1, 32'h7,    32'h4,  3'd0, 4, 0, 4'hf, 32'h7,   32'he};
    tbl[9]  = '{0, 0, 32'h0,    32'h0,  3'd2, 2, 0, 4'h3, 32'h15,  32'h1c};
    tbl[10] = '{0, 0, 32'h0,    32'h0,  3'd4, 0, 0, 4'h0, 32'h0,   32'h0};
    tbl[11] = '{0, 0, 32'h0,    32'h0,  3'd5, 0, 0, 4'h0, 32'h0,   32'h0};
    repeat (2) @(posedge CLK);
    #1 reset = 0;
    chk("reset count", 32'(count), 0);
    chk("reset stall", 32'(stall), 0);
    chk("reset valid", 32'(ValidD), 0);
    chk("reset instr1", InstrD1, 0);
    chk("reset pc4", PCPlus4D4, 0);
    for (int v = 0; v < 12; v++) begin
      step(tbl[v].fl, tbl[v].pv, tbl[v].ib, tbl[v].pb, tbl[v].cons, $sformatf("vec%0d pre", v));
      chk($sformatf("vec%0d count", v), 32'(count), 32'(tbl[v].cnt));
      chk($sformatf("vec%0d stall", v), 32'(stall), 32'(tbl[v].stl));
      chk($sformatf("vec%0d valid", v), 32'(ValidD), 32'(tbl[v].vd));
      chk($sformatf("vec%0d instr1", v), InstrD1, tbl[v].i1);
      chk($sformatf("vec%0d instr2", v), InstrD2, tbl[v].i2);
    end
    for (int g = 0; g < 10; g++) begin
      if (g > 0) begin
        chk($sformatf("wrap%0d instr1", g), InstrD1, 32'h1000 + 32'(g - 1) * 32'h10);
        chk($sformatf("wrap%0d instr4", g), InstrD4, (32'h1000 + 32'(g - 1) * 32'h10) * 4);
        chk($sformatf("wrap%0d pc3", g), PCPlus4D3, (32'h4 * 32'(g)) * 3);
        chk($sformatf("wrap%0d count", g), 32'(count), 4);
      end
      step(0, 1, 32'h1000 + 32'(g) * 32'h10, 32'h4 * 32'(g + 1), 3'd4, $sformatf("wrap%0d", g));
    end
    step(0, 1, 32'h77, 32'h4, 3'd0, "pre-reset");
    reset = 1; flush = 1; push_valid = 1;
    @(posedge CLK); #1;
    reset = 0; flush = 0; push_valid = 0; q.delete();
    chk("midreset count", 32'(count), 0);
    chk("midreset valid", 32'(ValidD), 0);
    chk("midreset instr1", InstrD1, 0);
    chk("midreset stall", 32'(stall), 0);
    for (int r = 0; r < 400; r++)
      step($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, $urandom, $urandom,
           3'($urandom_range(0, 7)), $sformatf("rand%0d", r));
    #1 model_check("final");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
